// File: rtl/ram_arbiter_pkg.sv
// Shared types for the fetch/data RAM arbiter: FSM states, port ids, helpers.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  // Width of the read-latency down-counter; covers RD_LAT 1..4.
  localparam int CNT_W = 2;

  // Grant choice: a lone pending slot wins outright; on a tie the port
  // that was not granted last time wins.
  function automatic port_e pick_winner(input logic pend_if, input logic pend_d,
                                        input port_e rr_last);
    if (pend_if && pend_d) begin
      return (rr_last == PORT_IF) ? PORT_D : PORT_IF;
    end else if (pend_d) begin
      return PORT_D;
    end else begin
      return PORT_IF;
    end
  endfunction

endpackage

// File: rtl/ram_arbiter_arb_slot.sv
// Per-port pending slot: captures a one-cycle request pulse with its address/data.
// Latency: pend_o rises the cycle after req_i.
// Backpressure: none; a request hitting a still-pending slot is dropped and flagged.
module arb_slot
  import ram_arbiter_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              done_i,
  input  logic              wen_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic              pend_o,
  output logic              wen_o,
  output logic [AWIDTH-1:0] addr_o,
  output logic [DWIDTH-1:0] wdata_o,
  output logic              ovf_o
);

  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              wen_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              accept;

  // A request is taken when the slot is empty or is being retired this same cycle.
  always_comb begin
    accept = req_i && (!pend_q || done_i);
    pend_d = (pend_q && !done_i) || req_i;
    ovf_d  = ovf_q || (req_i && pend_q && !done_i);
  end

  // Slot flags and the captured request fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      if (accept) begin
        wen_q   <= wen_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end

  assign pend_o  = pend_q;
  assign ovf_o   = ovf_q;
  assign wen_o   = wen_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data ports.
// Latency: req at T -> mem_cs at T+2; read valid at T+3+RD_LAT, write done at T+3.
// Backpressure: none; one pending slot per port, an extra pulse is dropped and ovf_err set.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16,
  parameter int RD_LAT = 1   // legal range 1..4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic [DWIDTH-1:0] if_data,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              busy,
  output logic              ovf_err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

  logic              if_pend, d_pend;
  logic              if_ovf, d_ovf;
  logic              if_slot_wen, d_slot_wen;
  logic [AWIDTH-1:0] if_slot_addr, d_slot_addr;
  logic [DWIDTH-1:0] if_slot_wdata, d_slot_wdata;
  logic              if_done, d_done;

  state_e            state_q, state_d;
  // rr_last_q is loaded at grant time, so while busy it also names the current winner.
  port_e             rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DWIDTH-1:0] if_data_q, if_data_d;
  logic [DWIDTH-1:0] d_rdata_q, d_rdata_d;

  logic              win_wen;
  logic [AWIDTH-1:0] win_addr;
  logic [DWIDTH-1:0] win_wdata;
  logic              any_pend;
  logic              rd_capture;

  // Fetch slot never writes, so its write enable and write data are tied off.
  arb_slot #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_if_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (if_req),
    .done_i  (if_done),
    .wen_i   (1'b0),
    .addr_i  (if_addr),
    .wdata_i ('0),
    .pend_o  (if_pend),
    .wen_o   (if_slot_wen),
    .addr_o  (if_slot_addr),
    .wdata_o (if_slot_wdata),
    .ovf_o   (if_ovf)
  );

  arb_slot #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_d_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (d_req),
    .done_i  (d_done),
    .wen_i   (d_wen),
    .addr_i  (d_addr),
    .wdata_i (d_wdata),
    .pend_o  (d_pend),
    .wen_o   (d_slot_wen),
    .addr_o  (d_slot_addr),
    .wdata_o (d_slot_wdata),
    .ovf_o   (d_ovf)
  );

  // Select the granted slot's request fields.
  always_comb begin
    any_pend = if_pend || d_pend;
    if (rr_last_q == PORT_D) begin
      win_wen   = d_slot_wen;
      win_addr  = d_slot_addr;
      win_wdata = d_slot_wdata;
    end else begin
      win_wen   = if_slot_wen;
      win_addr  = if_slot_addr;
      win_wdata = if_slot_wdata;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: grant, one access cycle, optional read wait, one response cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_pend) state_d = ST_ACCESS;
      ST_ACCESS: state_d = win_wen ? ST_RESP : ST_WAIT;
      ST_WAIT:   if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: RAM strobe with zeroed side-band when idle, valid pulses, busy.
  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_valid  = 1'b0;
    d_valid   = 1'b0;
    busy      = (state_q != ST_IDLE);
    if (state_q == ST_ACCESS) begin
      mem_cs    = 1'b1;
      mem_we    = win_wen;
      mem_addr  = win_addr;
      mem_wdata = win_wdata;
    end
    if (state_q == ST_RESP) begin
      if_valid = (rr_last_q == PORT_IF);
      d_valid  = (rr_last_q == PORT_D);
    end
  end

  assign if_done = if_valid;
  assign d_done  = d_valid;

  // Datapath next-state: round-robin pointer, saturating read counter, read capture.
  always_comb begin
    rr_last_d  = rr_last_q;
    cnt_d      = cnt_q;
    if_data_d  = if_data_q;
    d_rdata_d  = d_rdata_q;
    rd_capture = (state_q == ST_WAIT) && (cnt_q == '0);
    if ((state_q == ST_IDLE) && any_pend) begin
      rr_last_d = pick_winner(if_pend, d_pend, rr_last_q);
    end
    if ((state_q == ST_ACCESS) && !win_wen) begin
      cnt_d = CNT_LOAD;
    end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (rd_capture) begin
      if (rr_last_q == PORT_IF) begin
        if_data_d = mem_rdata;
      end else begin
        d_rdata_d = mem_rdata;
      end
    end
  end

  // Datapath registers; the pointer resets to DATA so fetch wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last_q <= PORT_D;
      cnt_q     <= '0;
      if_data_q <= '0;
      d_rdata_q <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      if_data_q <= if_data_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign if_data = if_data_q;
  assign d_rdata = d_rdata_q;
  assign ovf_err = if_ovf || d_ovf;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: four instances with RD_LAT 1..4 share stimulus.
// Each instance has its own RAM model; expected responses and level probes are queued.
// A negedge monitor pops and compares, then prints the summary.
module tb_ram_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          if_req, d_req, d_wen;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          ram_load;
  logic          fin = 1'b0;

  logic [N-1:0]  if_valid_w, d_valid_w, mem_cs_w, mem_we_w, busy_w, ovf_w;
  logic [DW-1:0] if_data_w [N];
  logic [DW-1:0] d_rdata_w [N];
  logic [DW-1:0] mem_wdata_w [N];
  logic [DW-1:0] mem_rdata_w [N];
  logic [AW-1:0] mem_addr_w [N];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ram_init(input logic [7:0] a);
    if (a == 8'h10) return 16'h1234;
    return 16'h5A00 ^ {8'h00, a};
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_inst
    logic [15:0] ram [256];
    logic [15:0] pipe [4];

    always @(posedge clk) begin
      if (ram_load) begin
        for (int i = 0; i < 256; i++) ram[i] <= ram_init(i[7:0]);
        for (int k = 0; k < 4; k++) pipe[k] <= 16'h0000;
      end else begin
        pipe[0] <= (mem_cs_w[g] && !mem_we_w[g]) ? ram[mem_addr_w[g][7:0]] : 16'hDEAD;
        for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        if (mem_cs_w[g] && mem_we_w[g]) ram[mem_addr_w[g][7:0]] <= mem_wdata_w[g];
      end
    end

    assign mem_rdata_w[g] = pipe[g];

    ram_arbiter #(
      .DWIDTH (DW),
      .AWIDTH (AW),
      .RD_LAT (g + 1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_data   (if_data_w[g]),
      .if_valid  (if_valid_w[g]),
      .d_req     (d_req),
      .d_wen     (d_wen),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata_w[g]),
      .d_valid   (d_valid_w[g]),
      .mem_cs    (mem_cs_w[g]),
      .mem_we    (mem_we_w[g]),
      .mem_addr  (mem_addr_w[g]),
      .mem_wdata (mem_wdata_w[g]),
      .mem_rdata (mem_rdata_w[g]),
      .busy      (busy_w[g]),
      .ovf_err   (ovf_w[g])
    );
  end

  // ---------------- scoreboard storage ----------------
  typedef struct {
    int          inst;
    logic        is_d;
    logic        chk_data;
    logic [15:0] data;
    int          due;
  } exp_t;

  typedef enum int {K_BUSY, K_OVF, K_CS, K_WE, K_ADDR, K_WDATA, K_IFDATA, K_DRDATA} kind_e;

  typedef struct {
    int          inst;
    kind_e       kind;
    logic [15:0] val;
    int          due;
  } lvl_t;

  exp_t exp_q[$];
  lvl_t lvl_q[$];

  // Response expectation for every instance: due = base + mul * RD_LAT.
  task automatic push_resp(input logic is_d, input logic chk, input logic [15:0] data,
                           input int base, input int mul);
    exp_t e;
    for (int g = 0; g < N; g++) begin
      e.inst = g; e.is_d = is_d; e.chk_data = chk; e.data = data;
      e.due = base + mul * (g + 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_lvl(input kind_e k, input logic [15:0] v, input int due);
    lvl_t l;
    for (int g = 0; g < N; g++) begin
      l.inst = g; l.kind = k; l.val = v; l.due = due;
      lvl_q.push_back(l);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] shadow [256];
  int t;

  initial begin
    rst_n = 1'b0; ram_load = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) shadow[i] = ram_init(i[7:0]);
    tick(3);
    rst_n = 1'b1; ram_load = 1'b0;
    // Reset state.
    push_lvl(K_BUSY, 16'h0, cyc);
    push_lvl(K_OVF, 16'h0, cyc);
    push_lvl(K_CS, 16'h0, cyc);
    push_lvl(K_IFDATA, 16'h0, cyc);
    push_lvl(K_DRDATA, 16'h0, cyc);
    tick(2);

    // Fetch only.
    t = cyc;
    if_addr = 16'h0010; if_req = 1'b1;
    push_lvl(K_CS, 16'h1, t + 2);
    push_lvl(K_ADDR, 16'h0010, t + 2);
    push_lvl(K_BUSY, 16'h1, t + 2);
    push_resp(1'b0, 1'b1, 16'h1234, t + 3, 1);
    tick(1); if_req = 1'b0;
    tick(10);

    // Data write then read back.
    t = cyc;
    d_addr = 16'h0040; d_wen = 1'b1; d_wdata = 16'hBEEF; d_req = 1'b1;
    shadow[8'h40] = 16'hBEEF;
    push_lvl(K_WE, 16'h1, t + 2);
    push_lvl(K_WDATA, 16'hBEEF, t + 2);
    push_lvl(K_WE, 16'h0, t + 3);
    push_lvl(K_ADDR, 16'h0000, t + 3);
    push_resp(1'b1, 1'b0, 16'h0000, t + 3, 0);
    tick(1); d_req = 1'b0; d_wen = 1'b0; d_wdata = '0;
    tick(8);
    t = cyc;
    d_addr = 16'h0040; d_req = 1'b1;
    push_resp(1'b1, 1'b1, 16'hBEEF, t + 3, 1);
    push_lvl(K_DRDATA, 16'hBEEF, t + 11);
    tick(1); d_req = 1'b0;
    tick(12);

    // Two ties in a row: fetch must win both.
    for (int rep = 0; rep < 2; rep++) begin
      t = cyc;
      if_addr = 16'h0020 + 16'(rep); d_addr = 16'h0021 + 16'(rep);
      if_req = 1'b1; d_req = 1'b1;
      push_resp(1'b0, 1'b1, shadow[8'h20 + 8'(rep)], t + 3, 1);
      push_resp(1'b1, 1'b1, shadow[8'h21 + 8'(rep)], t + 6, 2);
      tick(1); if_req = 1'b0; d_req = 1'b0;
      tick(20);
    end

    // Overflow: second data pulse while the first is pending.
    t = cyc;
    d_addr = 16'h0030; d_req = 1'b1;
    push_lvl(K_OVF, 16'h0, t + 1);
    push_lvl(K_OVF, 16'h1, t + 2);
    push_resp(1'b1, 1'b1, shadow[8'h30], t + 3, 1);
    tick(1);
    d_addr = 16'h0031;
    tick(1); d_req = 1'b0;
    tick(15);
    push_lvl(K_OVF, 16'h1, cyc);
    tick(2);

    // Reset while the read is waiting on RAM data.
    t = cyc;
    d_addr = 16'h0050; d_req = 1'b1;
    tick(1); d_req = 1'b0;
    tick(2);
    push_lvl(K_BUSY, 16'h1, t + 3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    push_lvl(K_BUSY, 16'h0, t + 4);
    push_lvl(K_CS, 16'h0, t + 4);
    push_lvl(K_OVF, 16'h0, t + 4);
    push_lvl(K_DRDATA, 16'h0, t + 4);
    tick(15);

    // Alternating sweep, including a data write seen by a later fetch.
    for (int k = 0; k < 10; k++) begin
      t = cyc;
      if (k == 8) begin
        d_addr = 16'h0085; d_wen = 1'b1; d_wdata = 16'h0F0F; d_req = 1'b1;
        shadow[8'h85] = 16'h0F0F;
        push_resp(1'b1, 1'b0, 16'h0000, t + 3, 0);
      end else if (k == 9) begin
        if_addr = 16'h0085; if_req = 1'b1;
        push_resp(1'b0, 1'b1, shadow[8'h85], t + 3, 1);
      end else if (k % 2 == 0) begin
        if_addr = 16'h0080 + 16'(k); if_req = 1'b1;
        push_resp(1'b0, 1'b1, shadow[8'h80 + 8'(k)], t + 3, 1);
      end else begin
        d_addr = 16'h0080 + 16'(k); d_req = 1'b1;
        push_resp(1'b1, 1'b1, shadow[8'h80 + 8'(k)], t + 3, 1);
      end
      tick(1);
      if_req = 1'b0; d_req = 1'b0; d_wen = 1'b0; d_wdata = '0;
      tick(7);
    end
    tick(10);
    fin = 1'b1;
    tick(5);
    $display("FAIL monitor did not finish the run");
    $fatal(1);
  end

  // ---------------- monitor ----------------
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] probe(input int g, input kind_e k);
    case (k)
      K_BUSY:   return {15'd0, busy_w[g]};
      K_OVF:    return {15'd0, ovf_w[g]};
      K_CS:     return {15'd0, mem_cs_w[g]};
      K_WE:     return {15'd0, mem_we_w[g]};
      K_ADDR:   return mem_addr_w[g];
      K_WDATA:  return mem_wdata_w[g];
      K_IFDATA: return if_data_w[g];
      default:  return d_rdata_w[g];
    endcase
  endfunction

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (if_valid_w[g] || d_valid_w[g]) begin
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (idx < 0 && exp_q[i].inst == g) idx = i;
        end
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL unexpected_valid inst%0d cyc %0d: if_valid=%0b d_valid=%0b, none expected",
                   g, cyc, if_valid_w[g], d_valid_w[g]);
        end else begin
          exp_t e;
          e = exp_q[idx];
          exp_q.delete(idx);
          if (d_valid_w[g] != e.is_d || if_valid_w[g] == e.is_d || cyc != e.due) begin
            errors++;
            $display("FAIL resp_timing inst%0d: got if_v=%0b d_v=%0b at cyc %0d, want d_port=%0b at cyc %0d",
                     g, if_valid_w[g], d_valid_w[g], cyc, e.is_d, e.due);
          end
          if (e.chk_data) begin
            logic [15:0] got;
            got = e.is_d ? d_rdata_w[g] : if_data_w[g];
            checks++;
            if (got !== e.data) begin
              errors++;
              $display("FAIL resp_data inst%0d cyc %0d: got %h want %h", g, cyc, got, e.data);
            end
          end
        end
      end
    end

    for (int i = lvl_q.size() - 1; i >= 0; i--) begin
      if (lvl_q[i].due <= cyc) begin
        logic [15:0] got;
        got = probe(lvl_q[i].inst, lvl_q[i].kind);
        checks++;
        if (lvl_q[i].due != cyc || got !== lvl_q[i].val) begin
          errors++;
          $display("FAIL level_%s inst%0d cyc %0d: got %h want %h (due %0d)",
                   lvl_q[i].kind.name(), lvl_q[i].inst, cyc, got, lvl_q[i].val, lvl_q[i].due);
        end
        lvl_q.delete(i);
      end
    end

    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL resp_timeout inst%0d: no valid by cyc %0d, wanted at cyc %0d",
                 exp_q[i].inst, cyc, exp_q[i].due);
        exp_q.delete(i);
      end
    end

    if (fin) begin
      checks++;
      if (exp_q.size() != 0 || lvl_q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d responses and %0d probes left, want 0 and 0",
                 exp_q.size(), lvl_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

endmodule
